// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared types for the execute-side branch resolver and the fetch-stage
// predictor's training port.
//   bpu_pred_t       : one in-flight prediction {pc, pc_predict}
//   bpu_update_t     : predictor training write {valid, br_pc, br_taken, target}
//   resolver_state_t : resolver FSM states
//   seq_next_pc()    : fall-through PC (pc + 4, wrapping mod 2^32)
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

    localparam logic [31:0] INSN_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_predict;
    } bpu_pred_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] br_pc;
        logic        br_taken;
        logic [31:0] target;
    } bpu_update_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } resolver_state_t;

    // Sequential successor; the 32-bit add wraps 0xFFFFFFFC to 0.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// -----------------------------------------------------------------------------
// pred_fifo
// Synchronous in-order FIFO of bpu_pred_t with a synchronous clear.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_clear       : drop all entries (pointers to 0), wins over push/pop
//   i_push/i_data : write one entry (ignored when full)
//   i_pop         : retire the head entry (ignored when empty)
//   o_head        : oldest entry
//   o_full        : count == DEPTH
//   o_count       : number of valid entries
// -----------------------------------------------------------------------------
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  bpu_pred_t                i_data,
    input  logic                     i_pop,
    output bpu_pred_t                o_head,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    bpu_pred_t      r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign w_do_push = i_push & ~o_full & ~i_clear;
    assign w_do_pop  = i_pop & (o_count != {(AW+1){1'b0}}) & ~i_clear;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; clear and reset both return to the empty state.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1'b1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1'b1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Holds each fetched instruction's predicted next PC until execute resolves it,
// flushes/redirects on a wrong prediction and emits predictor training updates.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   f_valid/f_pc/f_pc_predict   : fetched instruction and its predicted next PC
//   e_valid/e_is_br/e_taken/e_target : resolution of the oldest instruction
//   q_full                      : prediction queue full, fetch stalls
//   flush/redirect_pc           : squash younger work, correct fetch PC
//   upd_valid/upd_pc/upd_taken/upd_target : predictor training write
//   br_count/mispred_count      : saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [31:0]       f_pc,
    input  logic [31:0]       f_pc_predict,
    input  logic              e_valid,
    input  logic              e_is_br,
    input  logic              e_taken,
    input  logic [31:0]       e_target,
    output logic              q_full,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              upd_valid,
    output logic [31:0]       upd_pc,
    output logic              upd_taken,
    output logic [31:0]       upd_target,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0]   FC_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    resolver_state_t   r_state;
    resolver_state_t   w_state_nx;
    logic [FCW-1:0]    r_fcnt;
    logic [FCW-1:0]    w_fcnt_nx;
    logic              r_flush;
    logic [31:0]       r_redirect_pc;
    bpu_update_t       r_upd;
    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_mispred_count;

    bpu_pred_t         w_head;
    bpu_pred_t         w_fetch;
    logic              w_fifo_full;
    logic [AW:0]       w_count;
    logic              w_idle;
    logic              w_deq;
    logic              w_enq;
    logic              w_mispred;
    logic [31:0]       w_actual_pc;

    assign w_fetch     = '{pc: f_pc, pc_predict: f_pc_predict};
    assign w_idle      = (r_state == IDLE);
    assign w_deq       = e_valid & w_idle & (w_count != {(AW+1){1'b0}});
    assign w_actual_pc = (e_is_br & e_taken) ? e_target : seq_next_pc(w_head.pc);
    assign w_mispred   = w_deq & (w_actual_pc != w_head.pc_predict);
    // A fetch in the mispredict cycle is wrong-path and must not be queued.
    assign w_enq       = f_valid & w_idle & ~w_fifo_full & ~w_mispred;

    pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_mispred),
        .i_push  (w_enq),
        .i_data  (w_fetch),
        .i_pop   (w_deq),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_count (w_count)
    );

    // Next-state logic: FLUSH lasts FLUSH_CYCLES cycles via a down-counter.
    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        case (r_state)
            IDLE: begin
                if (w_mispred) begin
                    w_state_nx = FLUSH;
                    w_fcnt_nx  = FC_LOAD;
                end else begin
                    w_state_nx = IDLE;
                    w_fcnt_nx  = r_fcnt;
                end
            end
            FLUSH: begin
                if (r_fcnt == {FCW{1'b0}}) begin
                    w_state_nx = IDLE;
                    w_fcnt_nx  = {FCW{1'b0}};
                end else begin
                    w_state_nx = FLUSH;
                    w_fcnt_nx  = r_fcnt - FCW'(1'b1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_fcnt_nx  = {FCW{1'b0}};
            end
        endcase
    end

    // State register; flush is registered alongside so it tracks FLUSH exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_fcnt  <= {FCW{1'b0}};
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
            r_flush <= (w_state_nx == FLUSH);
        end
    end

    // Redirect target, predictor update and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_pc   <= 32'd0;
            r_upd           <= '{valid: 1'b0, br_pc: 32'd0, br_taken: 1'b0, target: 32'd0};
            r_br_count      <= {CNT_W{1'b0}};
            r_mispred_count <= {CNT_W{1'b0}};
        end else begin
            if (w_mispred) r_redirect_pc <= w_actual_pc;
            r_upd.valid <= w_deq & e_is_br;
            if (w_deq && e_is_br) begin
                r_upd.br_pc    <= w_head.pc;
                r_upd.br_taken <= e_taken;
                r_upd.target   <= e_target;
                if (r_br_count != CNT_MAX) r_br_count <= r_br_count + CNT_W'(1'b1);
            end
            if (w_mispred && (r_mispred_count != CNT_MAX))
                r_mispred_count <= r_mispred_count + CNT_W'(1'b1);
        end
    end

    assign q_full        = w_idle & w_fifo_full;
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign upd_valid     = r_upd.valid;
    assign upd_pc        = r_upd.br_pc;
    assign upd_taken     = r_upd.br_taken;
    assign upd_target    = r_upd.target;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    logic        clk = 1'b0;
    logic        rst, f_valid, e_valid, e_is_br, e_taken;
    logic [31:0] f_pc, f_pc_predict, e_target;
    logic        q_full, flush, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [CNT_W-1:0] br_count, mispred_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_pc_predict(f_pc_predict),
        .e_valid(e_valid), .e_is_br(e_is_br), .e_taken(e_taken), .e_target(e_target),
        .q_full(q_full), .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    typedef struct {
        logic        rst, fv;
        logic [31:0] fpc, fpred;
        logic        ev, br, tk;
        logic [31:0] tgt;
        logic        qf, fl;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg, bc, mc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    // reference model state
    ent_t        mq[$];
    int          m_flush_left;
    logic [31:0] m_redir, m_upc, m_utg, m_bc, m_mc;
    logic        m_uv, m_ut;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0;
        m_redir = 32'd0; m_upc = 32'd0; m_utg = 32'd0; m_bc = 32'd0; m_mc = 32'd0;
        m_uv = 1'b0; m_ut = 1'b0;
    endtask

    // One clock of architectural behaviour, evaluated from the current inputs.
    task automatic model_step();
        bit   idle, full, deq, mis, enq;
        ent_t h;
        logic [31:0] actual;
        if (rst) begin
            model_reset();
        end else begin
            idle = (m_flush_left == 0);
            full = idle && (mq.size() == DEPTH);
            deq  = e_valid && idle && (mq.size() > 0);
            mis  = 1'b0;
            m_uv = 1'b0;
            if (deq) begin
                h = mq.pop_front();
                actual = (e_is_br && e_taken) ? e_target : h.pc + 32'd4;
                mis = (actual != h.pred);
                if (e_is_br) begin
                    m_uv = 1'b1; m_upc = h.pc; m_ut = e_taken; m_utg = e_target;
                    if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
                end
                if (mis) begin
                    m_redir = actual;
                    if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
                end
            end
            enq = f_valid && idle && !full && !mis;
            if (mis) begin
                mq.delete();
                m_flush_left = FLUSH_CYCLES;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
            if (enq) mq.push_back('{pc: f_pc, pred: f_pc_predict});
        end
    endtask

    task automatic check_all(input logic qf, input logic fl, input logic [31:0] rpc,
                             input logic uv, input logic [31:0] upc, input logic ut,
                             input logic [31:0] utg, input logic [31:0] bc, input logic [31:0] mc);
        chk("q_full",        {31'd0, q_full},    {31'd0, qf});
        chk("flush",         {31'd0, flush},     {31'd0, fl});
        chk("redirect_pc",   redirect_pc,        rpc);
        chk("upd_valid",     {31'd0, upd_valid}, {31'd0, uv});
        chk("upd_pc",        upd_pc,             upc);
        chk("upd_taken",     {31'd0, upd_taken}, {31'd0, ut});
        chk("upd_target",    upd_target,         utg);
        chk("br_count",      br_count,           bc);
        chk("mispred_count", mispred_count,      mc);
    endtask

    vec_t vt[29];

    initial begin
        rst = 1'b1; f_valid = 1'b0; e_valid = 1'b0; e_is_br = 1'b0; e_taken = 1'b0;
        f_pc = 32'd0; f_pc_predict = 32'd0; e_target = 32'd0;

        //          rst   fv    fpc           fpred         ev    br    tk    tgt           qf    fl    rpc           uv    upc           ut    utg           bc     mc
        vt[0]  = '{1'b1,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[1]  = '{1'b0,1'b1,32'h100,      32'h104,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[2]  = '{1'b0,1'b1,32'h104,      32'h108,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[3]  = '{1'b0,1'b1,32'h108,      32'h10C,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[4]  = '{1'b0,1'b1,32'h10C,      32'h110,      1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[5]  = '{1'b0,1'b1,32'h110,      32'h114,      1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        // full queue blocks enqueue even with a same-cycle dequeue
        vt[6]  = '{1'b0,1'b1,32'h110,      32'h114,      1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[7]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[8]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[9]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        // empty queue: e_valid ignored
        vt[10] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,1'b1,32'h999,      1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[11] = '{1'b0,1'b1,32'h100,      32'h104,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[12] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,1'b0,32'h180,      1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b0,32'h180,      32'd1, 32'd0};
        vt[13] = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,32'h180,      32'd1, 32'd0};
        vt[14] = '{1'b0,1'b1,32'h200,      32'h204,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,32'h180,      32'd1, 32'd0};
        // taken mispredict with wrong-path fetch in the same cycle
        vt[15] = '{1'b0,1'b1,32'h204,      32'h208,      1'b1,1'b1,1'b1,32'h400,      1'b0,1'b1,32'h400,      1'b1,32'h200,      1'b1,32'h400,      32'd2, 32'd1};
        vt[16] = '{1'b0,1'b1,32'h400,      32'h404,      1'b1,1'b1,1'b1,32'h555,      1'b0,1'b1,32'h400,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd1};
        vt[17] = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h400,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd1};
        vt[18] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,1'b1,32'h777,      1'b0,1'b0,32'h400,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd1};
        // non-branch with stale BTB prediction
        vt[19] = '{1'b0,1'b1,32'h300,      32'h500,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h400,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd1};
        vt[20] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h304,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd2};
        vt[21] = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h304,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd2};
        vt[22] = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h304,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd2};
        // PC wrap: 0xFFFFFFFC + 4 == 0
        vt[23] = '{1'b0,1'b1,32'hFFFFFFFC, 32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h304,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd2};
        vt[24] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h304,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd2};
        // reset during FLUSH
        vt[25] = '{1'b0,1'b1,32'h600,      32'h604,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h304,      1'b0,32'h200,      1'b1,32'h400,      32'd2, 32'd2};
        vt[26] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,1'b1,32'h800,      1'b0,1'b1,32'h800,      1'b1,32'h600,      1'b1,32'h800,      32'd3, 32'd3};
        vt[27] = '{1'b1,1'b1,32'h700,      32'h704,      1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};
        vt[28] = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,1'b1,32'h900,      1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'd0, 32'd0};

        for (int i = 0; i < 29; i++) begin
            rst = vt[i].rst; f_valid = vt[i].fv; f_pc = vt[i].fpc; f_pc_predict = vt[i].fpred;
            e_valid = vt[i].ev; e_is_br = vt[i].br; e_taken = vt[i].tk; e_target = vt[i].tgt;
            @(posedge clk); #1;
            check_all(vt[i].qf, vt[i].fl, vt[i].rpc, vt[i].uv, vt[i].upc, vt[i].ut,
                      vt[i].utg, vt[i].bc, vt[i].mc);
        end

        // randomized traffic against the reference model
        rst = 1'b1; f_valid = 1'b0; e_valid = 1'b0;
        model_step();
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc_r;
            rst     = ($urandom_range(0, 299) == 0);
            pc_r    = {$urandom_range(0, 255), 2'b00};
            f_valid = $urandom_range(0, 1);
            f_pc    = pc_r;
            f_pc_predict = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 15), 6'd0} : pc_r + 32'd4;
            e_valid = $urandom_range(0, 1);
            e_is_br = $urandom_range(0, 1);
            e_taken = $urandom_range(0, 1);
            if (($urandom_range(0, 1) == 1) && (mq.size() > 0)) e_target = mq[0].pred;
            else e_target = {$urandom_range(0, 15), 6'd0};
            model_step();
            @(posedge clk); #1;
            check_all((m_flush_left == 0) && (mq.size() == DEPTH), (m_flush_left > 0),
                      m_redir, m_uv, m_upc, m_ut, m_utg, m_bc, m_mc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
